// File: rtl/ps2_pkg.sv
// Shared constants, event layout and FSM state type for the PS/2 receiver.
package ps2_pkg;

   // Prefix bytes that modify the following scan code
   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

   // Event word: {ext, brk, code[7:0]}
   localparam int EV_W       = 10;
   localparam int EV_EXT_BIT = 9;
   localparam int EV_BRK_BIT = 8;

   // Scan codes commonly used by game/control consumers
   localparam logic [7:0] KEY_W     = 8'h1D;
   localparam logic [7:0] KEY_A     = 8'h1C;
   localparam logic [7:0] KEY_S     = 8'h1B;
   localparam logic [7:0] KEY_D     = 8'h23;
   localparam logic [7:0] KEY_SPACE = 8'h29;
   localparam logic [7:0] KEY_ENTER = 8'h5A;
   // Arrow keys arrive with the extended prefix
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_RIGHT = 8'h74;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   // Assemble an event word from the prefix flags and the code byte
   function automatic logic [EV_W-1:0] make_event(input logic ext, input logic brk,
                                                  input logic [7:0] code);
      logic [EV_W-1:0] ev;
      ev             = '0;
      ev[7:0]        = code;
      ev[EV_BRK_BIT] = brk;
      ev[EV_EXT_BIT] = ext;
      return ev;
   endfunction

   // PS/2 uses odd parity over data plus parity bit
   function automatic logic parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; the head stays on rdata while valid,
// and the last popped word is held on rdata while empty.
module ps2_event_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   output logic         full,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] rdata
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [W-1:0]  last;
   logic          do_pop;
   logic          do_push;

   assign valid   = (count != '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = valid & ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign rdata   = valid ? mem[rd_ptr] : last;

   // Storage array; contents are only observable through count, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers, occupancy and the held copy of the last popped word
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            last   <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pin conditioning, frame checking, E0/F0 prefix
// decode and buffered key events with a valid/ready handshake.
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ps2_clk,
   input  logic            ps2_data,
   output logic            ev_valid,
   output logic [EV_W-1:0] ev_data,
   input  logic            ev_ready,
   output logic            parity_err,
   output logic            frame_err,
   output logic            timeout_err,
   output logic            overflow,
   output logic [7:0]      err_cnt
);

   localparam int FW = 4;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic            clk_s1, clk_s2, dat_s1, dat_s2;
   logic [FW-1:0]   flt_cnt;
   logic            flt_clk, flt_clk_d;
   logic            fe;
   ps2_state_t      state, state_nxt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            par_bit;
   logic [TW-1:0]   to_cnt;
   logic            tmo;
   logic            good_nxt, perr_nxt, ferr_nxt;
   logic            good_q;
   logic [7:0]      byte_q;
   logic            ext, brk;
   logic            push_q;
   logic [EV_W-1:0] ev_q;
   logic            fifo_full;
   logic            any_err;

   // Two-flop synchronisers; idle level of both pins is high
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // Clock glitch filter: flip only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         flt_clk   <= 1'b1;
         flt_clk_d <= 1'b1;
         flt_cnt   <= '0;
      end else begin
         flt_clk_d <= flt_clk;
         if (clk_s2 == flt_clk) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            flt_clk <= clk_s2;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + FW'(1);
         end
      end
   end

   assign fe  = flt_clk_d & ~flt_clk;
   // Abort when a mid-frame bit has waited TIMEOUT_CYCLES cycles for its edge
   assign tmo = (state != ST_IDLE) && !fe && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Frame FSM next state and frame verdicts
   always_comb begin
      state_nxt = state;
      good_nxt  = 1'b0;
      perr_nxt  = 1'b0;
      ferr_nxt  = 1'b0;
      if (tmo) begin
         state_nxt = ST_IDLE;
      end else if (fe) begin
         case (state)
            ST_IDLE: begin
               if (dat_s2) ferr_nxt  = 1'b1;
               else        state_nxt = ST_DATA;
            end
            ST_DATA: begin
               if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
            end
            ST_PARITY: state_nxt = ST_STOP;
            ST_STOP: begin
               state_nxt = ST_IDLE;
               if (!dat_s2)                      ferr_nxt = 1'b1;
               else if (!parity_ok(shreg, par_bit)) perr_nxt = 1'b1;
               else                              good_nxt = 1'b1;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // FSM state, bit shifter and inter-edge timeout counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         to_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE || fe || tmo) to_cnt <= '0;
         else                               to_cnt <= to_cnt + TW'(1);
         if (tmo) begin
            shreg   <= '0;
            bit_cnt <= '0;
         end else if (fe) begin
            case (state)
               ST_IDLE: bit_cnt <= '0;
               ST_DATA: begin
                  shreg   <= {dat_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               ST_PARITY: par_bit <= dat_s2;
               default: ;
            endcase
         end
      end
   end

   // Register error pulses and the completed byte
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         good_q      <= 1'b0;
         byte_q      <= '0;
      end else begin
         parity_err  <= perr_nxt;
         frame_err   <= ferr_nxt;
         timeout_err <= tmo;
         good_q      <= good_nxt;
         if (good_nxt) byte_q <= shreg;
      end
   end

   assign any_err = parity_err | frame_err | timeout_err;

   // Prefix decode: E0/F0 arm flags, any other byte becomes an event
   always_ff @(posedge clk) begin
      if (rst) begin
         ext    <= 1'b0;
         brk    <= 1'b0;
         push_q <= 1'b0;
         ev_q   <= '0;
      end else begin
         push_q <= 1'b0;
         if (any_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (good_q) begin
            if (byte_q == PS2_PREFIX_EXT) begin
               ext <= 1'b1;
            end else if (byte_q == PS2_PREFIX_BRK) begin
               brk <= 1'b1;
            end else begin
               push_q <= 1'b1;
               ev_q   <= make_event(ext, brk, byte_q);
               ext    <= 1'b0;
               brk    <= 1'b0;
            end
         end
      end
   end

   // Saturating error counter and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         if (any_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         if (push_q && fifo_full && !(ev_valid && ev_ready)) overflow <= 1'b1;
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EV_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_q),
      .wdata (ev_q),
      .full  (fifo_full),
      .ready (ev_ready),
      .valid (ev_valid),
      .rdata (ev_data)
   );

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: bit-banged PS/2 frames against a frame-level model.
module tb_ps2_scan_rx;

   localparam int FL    = 4;
   localparam int TO    = 300;
   localparam int DEPTH = 4;
   localparam int HALF  = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       ev_ready;
   logic       ev_valid;
   logic [9:0] ev_data;
   logic       parity_err, frame_err, timeout_err, overflow;
   logic [7:0] err_cnt;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int stop_fall_cyc = 0;
   int rise_cyc = -1;
   int n_perr = 0, n_ferr = 0, n_terr = 0;
   logic v_prev = 1'b0;

   // Frame-level reference model
   logic [9:0] exp_q[$];
   logic [9:0] got_q[$];
   bit m_ext, m_brk, m_ovf;
   int m_err;

   always #5 clk = ~clk;

   ps2_scan_rx #(
      .FILTER_LEN     (FL),
      .TIMEOUT_CYCLES (TO),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .ev_valid    (ev_valid),
      .ev_data     (ev_data),
      .ev_ready    (ev_ready),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .timeout_err (timeout_err),
      .overflow    (overflow),
      .err_cnt     (err_cnt)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Count error pulses and note when ev_valid rises
   always @(negedge clk) begin
      n_perr += int'(parity_err);
      n_ferr += int'(frame_err);
      n_terr += int'(timeout_err);
      if (ev_valid && !v_prev) rise_cyc = cyc;
      v_prev = ev_valid;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task model_reset();
      exp_q.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;
   endtask

   task model_err();
      m_ext = 0; m_brk = 0;
      if (m_err < 255) m_err++;
   endtask

   task model_frame(input logic [7:0] b, input bit par_good, input bit stop);
      if (!stop || !par_good) model_err();
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
         else m_ovf = 1;
         m_ext = 0; m_brk = 0;
      end
   endtask

   // Drive nbits of a frame; a short frame is left to time out unless aborted
   task send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                   input int nbits, input int glitch_at, input bit abort);
      logic [10:0] bits;
      bits = {stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         if (i == glitch_at) begin
            tick(10);
            ps2_clk = 1'b0;
            tick(FL - 1);
            ps2_clk = 1'b1;
            tick(HALF - 10 - (FL - 1));
         end else begin
            tick(HALF);
         end
         ps2_clk = 1'b0;
         if (i == 10) stop_fall_cyc = cyc;
         tick(HALF);
         ps2_clk = 1'b1;
      end
      if (abort) return;
      ps2_data = 1'b1;
      if (nbits < 11) begin
         tick(TO + 40);
         model_err();
      end else begin
         tick(HALF);
         model_frame(b, !bad_par, stop);
      end
   endtask

   task send(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 11, -1, 1'b0);
   endtask

   // Pop everything currently in the FIFO into got_q
   task collect();
      got_q.delete();
      @(negedge clk);
      for (int i = 0; i < 16 && ev_valid; i++) begin
         got_q.push_back(ev_data);
         ev_ready = 1'b1;
         @(posedge clk);
         #1;
         ev_ready = 1'b0;
         @(negedge clk);
      end
   endtask

   task test_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      n_vec++;
      if (ev_valid !== 1'b0 || ev_data !== 10'h000) begin
         n_err++; $display("FAIL reset ev: valid=%b data=%h, want 0/000", ev_valid, ev_data);
      end
      n_vec++;
      if ({parity_err, frame_err, timeout_err} !== 3'b000) begin
         n_err++; $display("FAIL reset pulses: %b, want 000", {parity_err, frame_err, timeout_err});
      end
      n_vec++;
      if (overflow !== 1'b0 || err_cnt !== 8'd0) begin
         n_err++; $display("FAIL reset status: ovf=%b err_cnt=%0d, want 0/0", overflow, err_cnt);
      end
   endtask

   task test_single();
      int p0, f0, t0, lat;
      p0 = n_perr; f0 = n_ferr; t0 = n_terr;
      rise_cyc = -1;
      send(8'h1C);
      lat = rise_cyc - stop_fall_cyc;
      n_vec++;
      if (rise_cyc < 0 || lat < FL + 3 || lat > FL + 8) begin
         n_err++; $display("FAIL single latency: %0d cycles, want %0d..%0d", lat, FL + 3, FL + 8);
      end
      n_vec++;
      if (n_perr != p0 || n_ferr != f0 || n_terr != t0) begin
         n_err++; $display("FAIL single pulses: p=%0d f=%0d t=%0d, want none", n_perr - p0, n_ferr - f0, n_terr - t0);
      end
      collect();
      n_vec++;
      if (got_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL single count: got %0d events, want %0d", got_q.size(), exp_q.size());
      end else foreach (got_q[i]) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL single event: got %h, want %h", got_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task test_prefix();
      send(8'hE0); send(8'hF0); send(8'h75); send(8'h5A);
      collect();
      n_vec++;
      if (got_q.size() != exp_q.size() || exp_q.size() != 2) begin
         n_err++; $display("FAIL prefix count: got %0d events, want %0d", got_q.size(), exp_q.size());
      end else foreach (got_q[i]) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL prefix event: got %h, want %h", got_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task test_parity();
      int p0;
      p0 = n_perr;
      send(8'hE0);
      send_frame(8'h1D, 1'b1, 1'b1, 11, -1, 1'b0);
      n_vec++;
      if (n_perr - p0 != 1) begin
         n_err++; $display("FAIL parity pulses: got %0d, want 1", n_perr - p0);
      end
      n_vec++;
      if (err_cnt !== 8'(m_err)) begin
         n_err++; $display("FAIL parity err_cnt: got %0d, want %0d", err_cnt, m_err);
      end
      send(8'h29);
      collect();
      n_vec++;
      if (got_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL parity count: got %0d events, want %0d", got_q.size(), exp_q.size());
      end else foreach (got_q[i]) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL parity event: got %h, want %h", got_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task test_timeout();
      int t0;
      t0 = n_terr;
      send(8'hF0);
      send_frame(8'h55, 1'b0, 1'b1, 6, -1, 1'b0);
      n_vec++;
      if (n_terr - t0 != 1) begin
         n_err++; $display("FAIL timeout pulses: got %0d, want 1", n_terr - t0);
      end
      send(8'h23);
      collect();
      n_vec++;
      if (got_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL timeout count: got %0d events, want %0d", got_q.size(), exp_q.size());
      end else foreach (got_q[i]) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL timeout event: got %h, want %h", got_q[i], exp_q[i]);
         end
      end
      n_vec++;
      if (err_cnt !== 8'(m_err)) begin
         n_err++; $display("FAIL timeout err_cnt: got %0d, want %0d", err_cnt, m_err);
      end
      exp_q.delete();
   endtask

   task test_glitch();
      send(8'hE0);
      send_frame(8'h74, 1'b0, 1'b1, 11, 4, 1'b0);
      send_frame(8'h6B, 1'b0, 1'b1, 11, 9, 1'b0);
      collect();
      n_vec++;
      if (got_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL glitch count: got %0d events, want %0d", got_q.size(), exp_q.size());
      end else foreach (got_q[i]) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL glitch event: got %h, want %h", got_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task test_overflow();
      send(8'h1C); send(8'h1D); send(8'h1B); send(8'h23); send(8'h29);
      @(negedge clk);
      n_vec++;
      if (overflow !== 1'b1 || !m_ovf) begin
         n_err++; $display("FAIL overflow flag: got %b, want 1", overflow);
      end
      collect();
      n_vec++;
      if (got_q.size() != exp_q.size() || exp_q.size() != DEPTH) begin
         n_err++; $display("FAIL overflow count: got %0d events, want %0d", got_q.size(), exp_q.size());
      end else foreach (got_q[i]) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL overflow event: got %h, want %h", got_q[i], exp_q[i]);
         end
      end
      n_vec++;
      if (ev_valid !== 1'b0 || ev_data !== exp_q[DEPTH-1]) begin
         n_err++; $display("FAIL overflow empty: valid=%b data=%h, want 0/%h", ev_valid, ev_data, exp_q[DEPTH-1]);
      end
      exp_q.delete();
   endtask

   task test_midreset();
      send(8'h1C);
      send_frame(8'h3C, 1'b0, 1'b1, 4, -1, 1'b1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      ps2_data = 1'b1;
      model_reset();
      @(negedge clk);
      n_vec++;
      if (ev_valid !== 1'b0 || ev_data !== 10'h000 || overflow !== 1'b0 || err_cnt !== 8'd0) begin
         n_err++; $display("FAIL midreset state: valid=%b data=%h ovf=%b err_cnt=%0d, want all 0",
                           ev_valid, ev_data, overflow, err_cnt);
      end
      tick(HALF);
      send(8'h5A);
      collect();
      n_vec++;
      if (got_q.size() != 1 || got_q[0] !== 10'h05A) begin
         n_err++; $display("FAIL midreset event: got %0d events first %h, want 1 event 05A",
                           got_q.size(), got_q.size() ? got_q[0] : 10'h3FF);
      end
      exp_q.delete();
   endtask

   task test_random();
      logic [7:0] b;
      int k, r, g;
      bit bp, st;
      for (int round = 0; round < 6; round++) begin
         k = int'($urandom_range(1, 5));
         for (int j = 0; j < k; j++) begin
            r = int'($urandom_range(0, 5));
            b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
            bp = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 7) != 0);
            g  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 10));
            send_frame(b, bp, st, 11, g, 1'b0);
         end
         collect();
         n_vec++;
         if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL random count: round %0d got %0d events, want %0d", round, got_q.size(), exp_q.size());
         end else foreach (got_q[i]) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
               n_err++; $display("FAIL random event: round %0d got %h, want %h", round, got_q[i], exp_q[i]);
            end
         end
         n_vec++;
         if (err_cnt !== 8'(m_err) || overflow !== m_ovf) begin
            n_err++; $display("FAIL random status: err_cnt=%0d ovf=%b, want %0d/%b", err_cnt, overflow, m_err, m_ovf);
         end
         exp_q.delete();
      end
   endtask

   initial begin
      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      ev_ready = 1'b0;
      test_reset();
      test_single();
      test_prefix();
      test_parity();
      test_timeout();
      test_glitch();
      test_overflow();
      test_midreset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
